// File: rtl/fetch_pkg.sv
// ============================================================================
// Module   : fetch_pkg
// Summary  : Shared types and constants for the instruction-fetch stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

package fetch_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_HOLD  = 3'd2,
    S_DRAIN = 3'd3,
    S_ERR   = 3'd4
  } fetch_state_t;

  // addi x0, x0, 0 -- what decode sees after a redirect
  localparam logic [31:0] NOP = 32'h0000_0013;

  localparam int TIMEOUT_DEFAULT = 15;

endpackage

`default_nettype wire

// File: rtl/fetch_timer.sv
// ============================================================================
// Module   : fetch_timer
// Summary  : 8-bit saturating cycle counter with clear/enable and expiry flag.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fetch_timer #(
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [7:0] C_LIMIT = 8'(LIMIT);

  logic [7:0] r_cnt;

  assign expired = (r_cnt == C_LIMIT);

  // Clear wins over enable so WAIT->DRAIN restarts the count cleanly.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_cnt <= 8'd0;
    end else if (enable && !expired) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// Module   : fetch_unit
// Summary  : Instruction fetch: PC -> req/ack imem read -> valid/ready decode.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 32,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  pc_i,
  input  logic               pc_valid_i,
  input  logic               flush_i,
  output logic               imem_req_o,
  output logic [ADDR_W-1:0]  imem_addr_o,
  input  logic               imem_ack_i,
  input  logic [INSTR_W-1:0] imem_rdata_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [ADDR_W-1:0]  instr_pc_o,
  output logic               instr_valid_o,
  input  logic               instr_ready_i,
  output logic               stall_o,
  output logic               misalign_o,
  output logic               timeout_o
);

  fetch_state_t r_state, w_state_d;

  logic               r_req,      w_req_d;
  logic [ADDR_W-1:0]  r_addr,     w_addr_d;
  logic [INSTR_W-1:0] r_instr,    w_instr_d;
  logic [ADDR_W-1:0]  r_instr_pc, w_instr_pc_d;
  logic               r_valid,    w_valid_d;
  logic               r_misalign, w_misalign_d;
  logic               r_timeout,  w_timeout_d;

  logic w_launch;
  logic w_tmr_clr;
  logic w_tmr_en;
  logic w_expired;

  fetch_timer #(
    .LIMIT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (w_tmr_clr),
    .enable  (w_tmr_en),
    .expired (w_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d    = r_state;
    w_req_d      = r_req;
    w_addr_d     = r_addr;
    w_instr_d    = r_instr;
    w_instr_pc_d = r_instr_pc;
    w_valid_d    = r_valid;
    w_misalign_d = r_misalign;
    w_timeout_d  = r_timeout;
    w_launch     = 1'b0;
    w_tmr_clr    = 1'b0;
    w_tmr_en     = 1'b0;

    if (flush_i) begin
      w_req_d      = 1'b0;
      w_valid_d    = 1'b0;
      w_misalign_d = 1'b0;
      w_timeout_d  = 1'b0;
      w_instr_d    = INSTR_W'(NOP);
      // An outstanding request must still see its ack before memory is reused.
      if (r_state == S_WAIT && !imem_ack_i) begin
        w_state_d = S_DRAIN;
        w_tmr_clr = 1'b1;
      end else begin
        w_state_d = S_IDLE;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          w_launch = pc_valid_i;
        end
        S_WAIT: begin
          w_tmr_en = 1'b1;
          if (imem_ack_i) begin
            w_instr_d = imem_rdata_i;
            w_req_d   = 1'b0;
            w_valid_d = 1'b1;
            w_state_d = S_HOLD;
          end else if (w_expired) begin
            w_req_d     = 1'b0;
            w_timeout_d = 1'b1;
            w_state_d   = S_ERR;
          end
        end
        S_HOLD: begin
          if (instr_ready_i) begin
            w_valid_d = 1'b0;
            w_state_d = S_IDLE;
            w_launch  = pc_valid_i;
          end
        end
        S_DRAIN: begin
          w_tmr_en = 1'b1;
          if (imem_ack_i || w_expired) begin
            w_state_d = S_IDLE;
          end
        end
        S_ERR: begin
          w_state_d = S_ERR;
        end
        default: begin
          w_state_d = S_IDLE;
        end
      endcase

      if (w_launch) begin
        w_addr_d     = pc_i;
        w_instr_pc_d = pc_i;
        if (pc_i[1:0] != 2'b00) begin
          w_misalign_d = 1'b1;
          w_state_d    = S_ERR;
        end else begin
          w_req_d   = 1'b1;
          w_tmr_clr = 1'b1;
          w_state_d = S_WAIT;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_req      <= 1'b0;
      r_addr     <= '0;
      r_instr    <= '0;
      r_instr_pc <= '0;
      r_valid    <= 1'b0;
      r_misalign <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_req      <= w_req_d;
      r_addr     <= w_addr_d;
      r_instr    <= w_instr_d;
      r_instr_pc <= w_instr_pc_d;
      r_valid    <= w_valid_d;
      r_misalign <= w_misalign_d;
      r_timeout  <= w_timeout_d;
    end
  end

  assign imem_req_o    = r_req;
  assign imem_addr_o   = r_addr;
  assign instr_o       = r_instr;
  assign instr_pc_o    = r_instr_pc;
  assign instr_valid_o = r_valid;
  assign misalign_o    = r_misalign;
  assign timeout_o     = r_timeout;

  // Releasing the PC in the accept cycle is what enables back-to-back fetch.
  assign stall_o = (r_state != S_IDLE) && !(r_state == S_HOLD && instr_ready_i);

endmodule

`default_nettype wire
